// File: rtl/nasti_word_master_if.sv
// NASTI (AXI4-style) channel bundle: AW/W/B/AR/R with master and slave views.
interface nasti_channel #(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 128,
    parameter int USER_WIDTH = 1
) ();
    logic [ID_WIDTH-1:0]     aw_id;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]              aw_len;
    logic [2:0]              aw_size;
    logic [1:0]              aw_burst;
    logic                    aw_lock;
    logic [3:0]              aw_cache;
    logic [2:0]              aw_prot;
    logic [3:0]              aw_qos;
    logic [3:0]              aw_region;
    logic [USER_WIDTH-1:0]   aw_user;
    logic                    aw_valid;
    logic                    aw_ready;

    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_last;
    logic [USER_WIDTH-1:0]   w_user;
    logic                    w_valid;
    logic                    w_ready;

    logic [ID_WIDTH-1:0]     b_id;
    logic [1:0]              b_resp;
    logic [USER_WIDTH-1:0]   b_user;
    logic                    b_valid;
    logic                    b_ready;

    logic [ID_WIDTH-1:0]     ar_id;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]              ar_len;
    logic [2:0]              ar_size;
    logic [1:0]              ar_burst;
    logic                    ar_lock;
    logic [3:0]              ar_cache;
    logic [2:0]              ar_prot;
    logic [3:0]              ar_qos;
    logic [3:0]              ar_region;
    logic [USER_WIDTH-1:0]   ar_user;
    logic                    ar_valid;
    logic                    ar_ready;

    logic [ID_WIDTH-1:0]     r_id;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic                    r_last;
    logic [USER_WIDTH-1:0]   r_user;
    logic                    r_valid;
    logic                    r_ready;

    modport master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
               aw_prot, aw_qos, aw_region, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
               ar_prot, ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
               aw_prot, aw_qos, aw_region, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
               ar_prot, ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/nasti_word_master.sv
// Single-word request/response port turned into single-beat NASTI
// transactions, one outstanding at a time. Every output is a register.
//
// Handshake rule on every port and channel: a transfer happens on the rising
// clock edge where valid and ready are both high; a valid, once raised, stays
// high with a stable payload until that edge, and ready may change freely.
module nasti_word_master #(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 128,
    parameter int USER_WIDTH = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic [DATA_WIDTH/8-1:0]   req_wstrb,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      rsp_err,
    output logic [2:0]                dbg_state,
    nasti_channel.master              nasti
);
    localparam int OFFS = $clog2(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {ADDR_WIDTH{1'b1}} << OFFS;

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_WRESP, S_READ, S_RDATA, S_RESP
    } state_t;

    state_t                    state_q, state_n;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_n;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_n;
    logic [DATA_WIDTH/8-1:0]   wstrb_q, wstrb_n;
    logic                      aw_valid_q, aw_valid_n;
    logic                      w_valid_q, w_valid_n;
    logic                      b_ready_q, b_ready_n;
    logic                      ar_valid_q, ar_valid_n;
    logic                      r_ready_q, r_ready_n;
    logic                      first_q, first_n;
    logic                      req_ready_n;
    logic                      rsp_valid_n;
    logic [DATA_WIDTH-1:0]     rsp_rdata_n;
    logic                      rsp_err_n;

    assign dbg_state = state_q;

    // Constant transaction attributes; payloads come from the latched request.
    assign nasti.aw_id     = '0;
    assign nasti.aw_addr   = addr_q;
    assign nasti.aw_len    = 8'd0;
    assign nasti.aw_size   = 3'(OFFS);
    assign nasti.aw_burst  = 2'b01;
    assign nasti.aw_lock   = 1'b0;
    assign nasti.aw_cache  = 4'd0;
    assign nasti.aw_prot   = 3'd0;
    assign nasti.aw_qos    = 4'd0;
    assign nasti.aw_region = 4'd0;
    assign nasti.aw_user   = '0;
    assign nasti.aw_valid  = aw_valid_q;
    assign nasti.w_data    = wdata_q;
    assign nasti.w_strb    = wstrb_q;
    assign nasti.w_last    = 1'b1;
    assign nasti.w_user    = '0;
    assign nasti.w_valid   = w_valid_q;
    assign nasti.b_ready   = b_ready_q;
    assign nasti.ar_id     = '0;
    assign nasti.ar_addr   = addr_q;
    assign nasti.ar_len    = 8'd0;
    assign nasti.ar_size   = 3'(OFFS);
    assign nasti.ar_burst  = 2'b01;
    assign nasti.ar_lock   = 1'b0;
    assign nasti.ar_cache  = 4'd0;
    assign nasti.ar_prot   = 3'd0;
    assign nasti.ar_qos    = 4'd0;
    assign nasti.ar_region = 4'd0;
    assign nasti.ar_user   = '0;
    assign nasti.ar_valid  = ar_valid_q;
    assign nasti.r_ready   = r_ready_q;

    // State and registered outputs; reset drops every valid/ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            b_ready_q  <= 1'b0;
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b0;
            first_q    <= 1'b0;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state_q    <= state_n;
            addr_q     <= addr_n;
            wdata_q    <= wdata_n;
            wstrb_q    <= wstrb_n;
            aw_valid_q <= aw_valid_n;
            w_valid_q  <= w_valid_n;
            b_ready_q  <= b_ready_n;
            ar_valid_q <= ar_valid_n;
            r_ready_q  <= r_ready_n;
            first_q    <= first_n;
            req_ready  <= req_ready_n;
            rsp_valid  <= rsp_valid_n;
            rsp_rdata  <= rsp_rdata_n;
            rsp_err    <= rsp_err_n;
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_n     = state_q;
        addr_n      = addr_q;
        wdata_n     = wdata_q;
        wstrb_n     = wstrb_q;
        aw_valid_n  = aw_valid_q;
        w_valid_n   = w_valid_q;
        b_ready_n   = b_ready_q;
        ar_valid_n  = ar_valid_q;
        r_ready_n   = r_ready_q;
        first_n     = first_q;
        rsp_valid_n = rsp_valid;
        rsp_rdata_n = rsp_rdata;
        rsp_err_n   = rsp_err;

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    addr_n      = req_addr & ADDR_MASK;
                    wdata_n     = req_wdata;
                    wstrb_n     = req_wstrb;
                    rsp_rdata_n = '0;
                    rsp_err_n   = 1'b0;
                    if (req_write) begin
                        state_n    = S_WRITE;
                        aw_valid_n = 1'b1;
                        w_valid_n  = 1'b1;
                    end else begin
                        state_n    = S_READ;
                        ar_valid_n = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                // AW and W complete independently, in any order.
                if (nasti.aw_ready) aw_valid_n = 1'b0;
                if (nasti.w_ready)  w_valid_n  = 1'b0;
                if (!aw_valid_n && !w_valid_n) begin
                    state_n   = S_WRESP;
                    b_ready_n = 1'b1;
                end
            end
            S_WRESP: begin
                if (nasti.b_valid) begin
                    b_ready_n   = 1'b0;
                    rsp_err_n   = (nasti.b_resp != 2'b00);
                    rsp_rdata_n = '0;
                    rsp_valid_n = 1'b1;
                    state_n     = S_RESP;
                end
            end
            S_READ: begin
                if (nasti.ar_ready) begin
                    ar_valid_n = 1'b0;
                    r_ready_n  = 1'b1;
                    first_n    = 1'b1;
                    state_n    = S_RDATA;
                end
            end
            S_RDATA: begin
                // Only the first beat carries data; a first beat without
                // r_last is an anomaly and the rest of the burst is drained.
                if (nasti.r_valid) begin
                    if (first_q) rsp_rdata_n = nasti.r_data;
                    rsp_err_n = rsp_err | (nasti.r_resp != 2'b00)
                              | (first_q & ~nasti.r_last);
                    first_n = 1'b0;
                    if (nasti.r_last) begin
                        r_ready_n   = 1'b0;
                        rsp_valid_n = 1'b1;
                        state_n     = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    state_n     = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase

        req_ready_n = (state_n == S_IDLE);
    end
endmodule

// File: tb/tb_nasti_word_master.sv
// Bench for nasti_word_master: NASTI slave model with configurable delays and
// responses, a driver task, and a response scoreboard checked by a monitor.
module tb_nasti_word_master;
    localparam int AW = 16;
    localparam int DW = 128;
    localparam int SW = DW / 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [SW-1:0] req_wstrb;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic [2:0]    dbg_state;

    nasti_channel #(.ID_WIDTH(1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(1)) nasti ();

    nasti_word_master #(.ID_WIDTH(1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .dbg_state(dbg_state), .nasti(nasti)
    );

    // ---------------- checking helpers ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [DW:0] act, input logic [DW:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                            input logic [SW-1:0] s);
        logic [DW-1:0] r;
        r = old;
        for (int i = 0; i < SW; i++)
            if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
        return r;
    endfunction

    // ---------------- configuration and expectations ----------------
    int            cfg_aw_delay = 0, cfg_w_delay = 0, cfg_ar_delay = 0;
    int            cfg_r_beats = 1, cfg_rsp_delay = 0;
    logic [1:0]    cfg_b_resp = 2'b00, cfg_r_resp = 2'b00;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_wdata = '0;
    logic [SW-1:0] exp_wstrb = '0;

    logic [DW-1:0] ref_mem [int];   // reference model: word store by aligned address
    logic [DW-1:0] slv_mem [int];   // slave memory, written only by what the DUT sends
    logic [DW:0]   exp_q [$];       // {err, rdata}

    // ---------------- NASTI slave model ----------------
    bit            aw_got, w_got, ar_got, aw_fire, w_fire, b_fire, ar_fire, r_fire;
    int            aw_cnt, w_cnt, ar_cnt, r_beat, r_acc = 0;
    logic [AW-1:0] s_awaddr, s_araddr;
    logic [DW-1:0] s_wdata, s_word;
    logic [SW-1:0] s_wstrb;

    always @(negedge clk) begin
        if (rst) begin
            aw_got = 0; w_got = 0; ar_got = 0;
            aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_beat = 0;
            nasti.aw_ready = 0; nasti.w_ready = 0; nasti.ar_ready = 0;
            nasti.b_valid = 0; nasti.b_resp = 0; nasti.b_id = 0; nasti.b_user = 0;
            nasti.r_valid = 0; nasti.r_resp = 0; nasti.r_id = 0; nasti.r_user = 0;
            nasti.r_data = '0; nasti.r_last = 0;
        end else begin
            // commit the transfers that happened on the edge just passed
            if (aw_fire) aw_got = 1;
            if (w_fire)  w_got  = 1;
            if (ar_fire) ar_got = 1;
            if (b_fire) begin
                nasti.b_valid = 0; aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0;
            end
            if (r_fire) begin
                r_acc++; r_beat++;
                if (r_beat >= cfg_r_beats) begin ar_got = 0; r_beat = 0; ar_cnt = 0; end
            end
            aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
            nasti.aw_ready = 0; nasti.w_ready = 0; nasti.ar_ready = 0;

            chk("b_ready_early", nasti.b_ready && !(aw_got && w_got), 0);
            chk("r_ready_stray", nasti.r_ready && !ar_got, 0);
            if (aw_got) chk("aw_drop", nasti.aw_valid, 0);
            if (w_got)  chk("w_drop", nasti.w_valid, 0);
            if (ar_got) chk("ar_drop", nasti.ar_valid, 0);

            if (nasti.aw_valid && !aw_got) begin
                chk("aw_addr", nasti.aw_addr, exp_addr);
                chk("aw_const", {nasti.aw_id, nasti.aw_len, nasti.aw_size, nasti.aw_burst,
                                 nasti.aw_lock, nasti.aw_cache, nasti.aw_prot, nasti.aw_qos,
                                 nasti.aw_region, nasti.aw_user},
                                {1'b0, 8'd0, 3'd4, 2'd1, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 1'b0});
                if (aw_cnt >= cfg_aw_delay) begin
                    nasti.aw_ready = 1; aw_fire = 1; s_awaddr = nasti.aw_addr;
                end else aw_cnt++;
            end
            if (nasti.w_valid && !w_got) begin
                chk("w_data", nasti.w_data, exp_wdata);
                chk("w_strb", nasti.w_strb, exp_wstrb);
                chk("w_last_user", {nasti.w_last, nasti.w_user}, 2'b10);
                if (w_cnt >= cfg_w_delay) begin
                    nasti.w_ready = 1; w_fire = 1; s_wdata = nasti.w_data; s_wstrb = nasti.w_strb;
                end else w_cnt++;
            end
            if (aw_got && w_got && !nasti.b_valid) begin
                s_word = slv_mem.exists(int'(s_awaddr)) ? slv_mem[int'(s_awaddr)] : '0;
                slv_mem[int'(s_awaddr)] = merge(s_word, s_wdata, s_wstrb);
                nasti.b_valid = 1;
                nasti.b_resp  = cfg_b_resp;
            end
            if (nasti.b_valid && nasti.b_ready) b_fire = 1;

            if (nasti.ar_valid && !ar_got) begin
                chk("ar_addr", nasti.ar_addr, exp_addr);
                chk("ar_const", {nasti.ar_id, nasti.ar_len, nasti.ar_size, nasti.ar_burst,
                                 nasti.ar_lock, nasti.ar_cache, nasti.ar_prot, nasti.ar_qos,
                                 nasti.ar_region, nasti.ar_user},
                                {1'b0, 8'd0, 3'd4, 2'd1, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 1'b0});
                if (ar_cnt >= cfg_ar_delay) begin
                    nasti.ar_ready = 1; ar_fire = 1; s_araddr = nasti.ar_addr;
                end else ar_cnt++;
            end
            if (ar_got && r_beat < cfg_r_beats) begin
                nasti.r_valid = 1;
                nasti.r_resp  = cfg_r_resp;
                nasti.r_last  = (r_beat == cfg_r_beats - 1);
                if (r_beat == 0)
                    nasti.r_data = slv_mem.exists(int'(s_araddr)) ? slv_mem[int'(s_araddr)] : '0;
                else
                    nasti.r_data = {4{32'hBAD0_0000 + 32'(r_beat)}};
                if (nasti.r_ready) r_fire = 1;
            end else begin
                nasti.r_valid = 0;
                nasti.r_last  = 0;
            end
        end
    end

    // ---------------- response consumer ----------------
    int rsp_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (rst || !rsp_valid) begin
            rsp_ready = 0; rsp_cnt = 0;
        end else begin
            rsp_ready = (rsp_cnt >= cfg_rsp_delay);
            rsp_cnt++;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [DW:0] mon_e, held;
    bit          hold_pend = 0, prev_v = 0;
    int          acc_cyc = 0, last_lat = -1;

    always @(negedge clk) begin
        if (rst) begin
            hold_pend = 0; prev_v = 0;
        end else begin
            if (rsp_valid && !prev_v) last_lat = cyc - acc_cyc;
            if (hold_pend) begin
                chk("rsp_hold_valid", rsp_valid, 1);
                chk("rsp_hold_data", {rsp_err, rsp_rdata}, held);
            end
            if (rsp_valid) chk("req_ready_busy", req_ready, 0);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
                else begin
                    mon_e = exp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, mon_e[DW-1:0]);
                    chk("rsp_err", rsp_err, mon_e[DW]);
                end
            end
            hold_pend = rsp_valid && !rsp_ready;
            held      = {rsp_err, rsp_rdata};
            prev_v    = rsp_valid;
        end
    end

    // ---------------- driver ----------------
    task automatic do_req(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s, input bit expect_rsp);
        logic [AW-1:0] al;
        logic [DW-1:0] word;
        int n;
        al = a & 16'hFFF0;
        exp_addr = al; exp_wdata = d; exp_wstrb = s;
        if (expect_rsp) begin
            word = ref_mem.exists(int'(al)) ? ref_mem[int'(al)] : '0;
            if (wr) begin
                ref_mem[int'(al)] = merge(word, d, s);
                exp_q.push_back({cfg_b_resp != 2'b00, {DW{1'b0}}});
            end else begin
                exp_q.push_back({(cfg_r_resp != 2'b00) || (cfg_r_beats != 1), word});
            end
        end
        @(posedge clk); #1;
        req_valid = 1; req_write = wr; req_addr = a; req_wdata = d; req_wstrb = s;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (req_ready) break;
            n++;
            if (n > 100) begin chk("req_accept_timeout", 1, 0); break; end
        end
        acc_cyc = cyc + 1;
        @(posedge clk); #1;
        req_valid = 0;
        if (expect_rsp) begin
            n = 0;
            while (exp_q.size() != 0 && n < 400) begin @(negedge clk); n++; end
            if (exp_q.size() != 0) begin chk("rsp_timeout", 1, 0); exp_q.delete(); end
            @(posedge clk);
        end
    endtask

    // ---------------- stimulus ----------------
    int base;
    initial begin
        req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", {req_ready, rsp_valid, rsp_err, nasti.aw_valid, nasti.w_valid,
                            nasti.ar_valid, nasti.b_ready, nasti.r_ready}, 0);
        chk("rst_rdata", rsp_rdata, 0);
        @(posedge clk); #1 rst = 0;
        @(posedge clk); @(negedge clk);
        chk("idle_req_ready", req_ready, 1);

        // write then read, ready slave, minimum latency
        do_req(1, 16'h0010, 128'h00112233_44556677_8899AABB_CCDDEEFF, 16'hFFFF, 1);
        chk("wr_latency", last_lat, 2);
        do_req(0, 16'h0010, '0, '0, 1);
        chk("rd_latency", last_lat, 2);

        // partial strobe, unaligned address
        do_req(1, 16'h0017, 128'hDEADBEEF, 16'h000F, 1);
        do_req(0, 16'h0010, '0, '0, 1);

        // channel skew both ways
        cfg_aw_delay = 5;
        do_req(1, 16'h0020, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 16'hFFFF, 1);
        cfg_aw_delay = 0; cfg_w_delay = 5;
        do_req(1, 16'h0030, 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000, 16'hF0F0, 1);
        cfg_w_delay = 0;
        do_req(0, 16'h0020, '0, '0, 1);
        do_req(0, 16'h0030, '0, '0, 1);

        // error responses
        cfg_b_resp = 2'b10;
        do_req(1, 16'h0040, 128'h0123_4567_89AB_CDEF, 16'h00FF, 1);
        cfg_b_resp = 2'b00; cfg_r_resp = 2'b11;
        do_req(0, 16'h0010, '0, '0, 1);
        cfg_r_resp = 2'b00;

        // response backpressure
        cfg_rsp_delay = 4;
        do_req(0, 16'h0040, '0, '0, 1);
        cfg_rsp_delay = 0;

        // malformed three-beat read
        cfg_r_beats = 3; base = r_acc;
        do_req(0, 16'h0020, '0, '0, 1);
        chk("r_beats_accepted", 32'(r_acc - base), 3);
        cfg_r_beats = 1;

        // reset in the middle of a write
        cfg_aw_delay = 100;
        do_req(1, 16'h0050, 128'hFEED_FACE, 16'hFFFF, 0);
        repeat (2) @(negedge clk);
        chk("aw_pending", nasti.aw_valid, 1);
        @(posedge clk); #1 rst = 1;
        @(posedge clk); @(negedge clk);
        chk("midrst_valids", {req_ready, rsp_valid, nasti.aw_valid, nasti.w_valid,
                              nasti.ar_valid, nasti.b_ready, nasti.r_ready}, 0);
        @(posedge clk); #1 rst = 0; cfg_aw_delay = 0;
        @(posedge clk); @(negedge clk);
        chk("post_rst_req_ready", req_ready, 1);
        do_req(0, 16'h0010, '0, '0, 1);
        do_req(0, 16'h0050, '0, '0, 1);

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            cfg_aw_delay  = $urandom_range(0, 3);
            cfg_w_delay   = $urandom_range(0, 3);
            cfg_ar_delay  = $urandom_range(0, 3);
            cfg_rsp_delay = $urandom_range(0, 3);
            cfg_b_resp    = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            cfg_r_resp    = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            cfg_r_beats   = ($urandom_range(0, 7) == 0) ? $urandom_range(2, 4) : 1;
            do_req(1'($urandom_range(0, 1)), 16'($urandom_range(0, 16'h7F)),
                   {$urandom, $urandom, $urandom, $urandom}, 16'($urandom), 1);
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end
endmodule
